// File: rtl/lii_arb_pkg.sv
// ----------------------------------------------------------------------------
// lii_arb_pkg
// Shared types and helpers for the LII router arbiters.
//   arb_state_e : arbiter packet state (IDLE / LOCKED)
//   clog2_min1  : index width for n requesters, never less than 1 bit
//   onehot      : one-hot vector with bit idx set (0 when idx >= n)
// ----------------------------------------------------------------------------
package lii_arb_pkg;

    // Widest requester count the onehot helper can encode.
    localparam int MAX_N = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_N-1:0] v;
        v = '0;
        if (idx < n) begin
            v = {{(MAX_N-1){1'b0}}, 1'b1} << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/lii_wrr_lock_arb_if.sv
// ----------------------------------------------------------------------------
// lii_wrr_lock_arb_if
// Request/grant bundle between N requesters and the weighted round-robin
// lock arbiter.
//   req     N     per-requester request
//   last    N     per-requester last-beat flag, qualified by req
//   weight  N*WW  packets per turn, field i = weight[i*WW +: WW]
//   accept  1     downstream takes the granted beat
//   gnt     N     one-hot grant
//   gnt_v   1     any grant
//   gnt_idx PW    index of granted requester (0 when gnt_v = 0)
//   locked  1     arbiter holds a multi-beat packet
// master: requester/downstream side.  slave: arbiter side.
// ----------------------------------------------------------------------------
interface lii_wrr_lock_arb_if
    import lii_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int WW = 4
);
    localparam int PW = clog2_min1(N);

    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*WW-1:0] weight;
    logic            accept;
    logic [N-1:0]    gnt;
    logic            gnt_v;
    logic [PW-1:0]   gnt_idx;
    logic            locked;

    modport master (
        output req, last, weight, accept,
        input  gnt, gnt_v, gnt_idx, locked
    );

    modport slave (
        input  req, last, weight, accept,
        output gnt, gnt_v, gnt_idx, locked
    );

endinterface

// File: rtl/lii_rr_pick.sv
// ----------------------------------------------------------------------------
// lii_rr_pick
// Combinational rotating-priority picker: grants the first set request
// starting at position ptr and wrapping N-1 -> 0.
//   req   in  N   requests
//   ptr   in  PW  highest-priority position
//   gnt   out N   one-hot grant (0 when no request)
//   idx   out PW  index of the grant (0 when no request)
//   found out 1   a request was granted
// ----------------------------------------------------------------------------
module lii_rr_pick
    import lii_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          found
);

    logic [PW-1:0] pos;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; otherwise a latch is inferred.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = PW'((int'(ptr) + k) % N);
            if (!found && req[pos]) begin
                found    = 1'b1;
                idx      = pos;
                gnt[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lii_wrr_lock_arb.sv
// ----------------------------------------------------------------------------
// lii_wrr_lock_arb
// N-way weighted round-robin arbiter with packet lock (LII router output).
// Each requester may complete up to max(weight,1) packets in a row before
// priority moves past it. With LOCK=1 a multi-beat packet keeps the grant
// until its last beat. The grant is combinational from registered state.
//   clk   in  clock
//   rstn  in  asynchronous active-low reset
//   bus   slave modport of lii_wrr_lock_arb_if (req/last/weight/accept in,
//         gnt/gnt_v/gnt_idx/locked out)
// ----------------------------------------------------------------------------
module lii_wrr_lock_arb
    import lii_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int WW   = 4,
    parameter bit LOCK = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    lii_wrr_lock_arb_if.slave  bus
);

    localparam int             PW      = clog2_min1(N);
    localparam logic [WW:0]    CNT_ONE = (WW+1)'(1);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] hold_idx_q, hold_idx_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [WW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  pick_gnt;
    logic [PW-1:0] pick_idx;
    logic          pick_found;

    logic [N-1:0]  gnt;
    logic          gnt_v;
    logic [PW-1:0] sel_idx;
    logic          sel_last;
    logic          xfer;
    logic          done;
    logic [WW:0]   w_eff;
    logic [WW:0]   base_p1;

    logic [WW-1:0] weight_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_weight
        assign weight_arr[i] = bus.weight[i*WW +: WW];
    end

    lii_rr_pick #(.N(N)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // While LOCKED only the holder is eligible; if it drops req the grant
    // goes away but the lock stays.
    always_comb begin
        gnt     = pick_gnt;
        gnt_v   = pick_found;
        sel_idx = pick_idx;
        if (state_q == LOCKED) begin
            gnt     = N'(onehot(32'(hold_idx_q), N)) & bus.req;
            gnt_v   = bus.req[hold_idx_q];
            sel_idx = hold_idx_q;
        end
    end

    assign bus.gnt     = gnt;
    assign bus.gnt_v   = gnt_v;
    assign bus.gnt_idx = gnt_v ? sel_idx : '0;
    assign bus.locked  = (state_q == LOCKED);

    assign xfer     = gnt_v & bus.accept;
    assign sel_last = bus.last[sel_idx];
    // Without locking every beat is a whole packet.
    assign done     = xfer & (!LOCK || sel_last);

    // Turn accounting is done one bit wider than cnt so base+1 never wraps.
    always_comb begin
        w_eff = {1'b0, weight_arr[sel_idx]};
        if (weight_arr[sel_idx] == '0) begin
            w_eff = CNT_ONE;
        end
        base_p1 = (sel_idx == ptr_q) ? ({1'b0, cnt_q} + CNT_ONE) : CNT_ONE;
    end

    always_comb begin
        state_d    = state_q;
        hold_idx_d = hold_idx_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;

        if (xfer) begin
            case (state_q)
                IDLE: begin
                    if (LOCK && !sel_last) begin
                        state_d    = LOCKED;
                        hold_idx_d = sel_idx;
                    end
                end
                LOCKED: begin
                    if (sel_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (done) begin
            if (base_p1 >= w_eff) begin
                cnt_d = '0;
                ptr_d = (sel_idx == PW'(N-1)) ? '0 : sel_idx + PW'(1);
            end else begin
                cnt_d = base_p1[WW-1:0];
                ptr_d = sel_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            state_q    <= IDLE;
            hold_idx_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_idx_q <= hold_idx_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
